// File: rtl/test_completion_monitor.sv
// test_completion_monitor: end-of-test monitor for simulation/emulation harnesses.
// Holds harness reset for RESET_CYCLES, then watches N_CHAN success/failure
// channel pairs, a runtime cycle limit and (optionally) a heartbeat watchdog,
// and latches a sticky pass/fail verdict with reason code and failing channel.
// Optional feature: define TEST_MONITOR_WATCHDOG_EN to build the heartbeat watchdog.
// fail_reason: 0 none, 1 channel failure, 2 timeout, 3 watchdog.
module test_completion_monitor #(
  parameter int unsigned N_CHAN       = 4,
  parameter int unsigned CYCLE_W      = 64,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned SUCCESS_ALL  = 1,
  parameter int unsigned WDOG_CYCLES  = 4096,
  localparam int unsigned CHAN_W      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CYCLE_W-1:0] max_cycles,
  input  logic [N_CHAN-1:0]  io_success,
  input  logic [N_CHAN-1:0]  io_failure,
  input  logic               heartbeat,
  output logic               harness_reset,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [1:0]         fail_reason,
  output logic [CHAN_W-1:0]  fail_chan,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_CHAN-1:0] seen;

  logic              chan_fail;
  logic [CHAN_W-1:0] first_fail;
  logic              timeout;
  logic              success;
  logic              wdog_expired;

  // Lowest-index failing channel; the found flag keeps the first hit.
  always_comb begin
    chan_fail  = 1'b0;
    first_fail = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (io_failure[i] && !chan_fail) begin
        chan_fail  = 1'b1;
        first_fail = CHAN_W'(i);
      end
    end
  end

  // Timeout and success conditions evaluated on live inputs and registered count.
  always_comb begin
    timeout = (max_cycles != '0) && (cycle_count >= max_cycles);
    if (SUCCESS_ALL != 0) success = &(seen | io_success);
    else                  success = |io_success;
  end

`ifdef TEST_MONITOR_WATCHDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_cnt;

  // Heartbeat watchdog: cleared outside RUN and on every heartbeat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (state != ST_RUN || heartbeat) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end

  assign wdog_expired = (state == ST_RUN) && !heartbeat &&
                        (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic unused_wdog;

  assign unused_wdog  = heartbeat ^ (WDOG_CYCLES == 0);
  assign wdog_expired = 1'b0;
`endif

  // Main sequencer: HOLD -> RUN -> PASS/FAIL, with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_HOLD;
      hold_cnt      <= '0;
      seen          <= '0;
      harness_reset <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      fail_reason   <= 2'd0;
      fail_chan     <= '0;
      cycle_count   <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          harness_reset <= 1'b1;
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            state         <= ST_RUN;
            harness_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          // The decision edge still counts as a RUN cycle, so the count
          // advances here before freezing in the terminal state.
          if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_W'(1);
          seen <= seen | io_success;
          if (chan_fail) begin
            state       <= ST_FAIL;
            done        <= 1'b1;
            fail        <= 1'b1;
            fail_reason <= 2'd1;
            fail_chan   <= first_fail;
          end else if (timeout) begin
            state       <= ST_FAIL;
            done        <= 1'b1;
            fail        <= 1'b1;
            fail_reason <= 2'd2;
          end else if (wdog_expired) begin
            state       <= ST_FAIL;
            done        <= 1'b1;
            fail        <= 1'b1;
            fail_reason <= 2'd3;
          end else if (success) begin
            state <= ST_PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
          end
        end
        default: begin
          // PASS / FAIL are terminal until reset.
        end
      endcase
    end
  end

endmodule
